// File: rtl/perf_event_counters.sv
// perf_event_counters
//   Performance-statistics unit that sits beside the processor core. It keeps
//   saturating counters for cycles, retired instructions, I-cache requests and
//   hits, and D-cache requests and hits. All counters freeze once halt retires.
//   The counters are read one at a time through a registered select/read port.
//
// Ports
//   clk, rst          core clock; asynchronous active-low reset
//   clr               synchronous clear of counters, err and state (beats events)
//   reg_wr, mem_wr    retire strobes (WB register write, MEM memory write)
//   halt              halt reached end of WB
//   ic_req, ic_hit    I-cache request / hit (hit qualified by req)
//   dc_req, dc_hit    D-cache request / hit (hit qualified by req)
//   rd_en, rd_sel     read request, counter select (0..5, 6/7 read as zero)
//   rd_valid, rd_data registered read response (pre-update counter value)
//   done              one-cycle pulse on entering HALTED
//   halted            level, state == HALTED
//   err               sticky: a hit was seen without its request

// Single saturating counter lane.
module perf_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            cnt <= '0;
    else if (clr)                        cnt <= '0;
    else if (inc && (cnt != {W{1'b1}})) cnt <= cnt + 1'b1;
  end
endmodule

module perf_event_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             reg_wr,
  input  logic             mem_wr,
  input  logic             halt,
  input  logic             ic_req,
  input  logic             ic_hit,
  input  logic             dc_req,
  input  logic             dc_hit,
  input  logic             rd_en,
  input  logic [2:0]       rd_sel,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             done,
  output logic             halted,
  output logic             err
);
  localparam int NUM_CNT = 6;

  typedef enum logic {RUN, HALTED} state_t;

  state_t                          state;
  logic                            run;
  logic                            hit_err;
  logic [NUM_CNT-1:0]              inc;
  logic [NUM_CNT-1:0][CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]                sel_val;

  // Events only count in RUN and never on a clear edge.
  assign run     = (state == RUN) && !clr;
  assign hit_err = (ic_hit && !ic_req) || (dc_hit && !dc_req);

  assign inc[0] = run;
  assign inc[1] = run && (halt || reg_wr || mem_wr);
  assign inc[2] = run && ic_req;
  assign inc[3] = run && ic_req && ic_hit;
  assign inc[4] = run && dc_req;
  assign inc[5] = run && dc_req && dc_hit;

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    perf_sat_cnt #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (inc[i]),
      .cnt (cnt[i])
    );
  end

  // Halt/clear FSM with registered done and sticky err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      done  <= 1'b0;
      err   <= 1'b0;
    end else if (clr) begin
      state <= RUN;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          if (hit_err) err <= 1'b1;
          if (halt) begin
            state <= HALTED;
            done  <= 1'b1;
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

  assign halted = (state == HALTED);

  always_comb begin
    sel_val = '0;
    case (rd_sel)
      3'd0:    sel_val = cnt[0];
      3'd1:    sel_val = cnt[1];
      3'd2:    sel_val = cnt[2];
      3'd3:    sel_val = cnt[3];
      3'd4:    sel_val = cnt[4];
      3'd5:    sel_val = cnt[5];
      default: sel_val = '0;
    endcase
  end

  // Read port samples counters before this edge's update; clr does not touch it,
  // so a read on the clear edge returns the pre-clear value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= sel_val;
    end
  end
endmodule

// File: tb/tb_perf_event_counters.sv
module tb_perf_event_counters;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 0, reg_wr = 0, mem_wr = 0, halt = 0;
  logic ic_req = 0, ic_hit = 0, dc_req = 0, dc_hit = 0, rd_en = 0;
  logic [2:0] rd_sel = '0;

  logic        a_valid, a_done, a_halted, a_err;
  logic [31:0] a_data;
  logic        b_valid, b_done, b_halted, b_err;
  logic [3:0]  b_data;

  always #5 clk = ~clk;

  perf_event_counters #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .clr(clr), .reg_wr(reg_wr), .mem_wr(mem_wr), .halt(halt),
    .ic_req(ic_req), .ic_hit(ic_hit), .dc_req(dc_req), .dc_hit(dc_hit),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_valid(a_valid), .rd_data(a_data),
    .done(a_done), .halted(a_halted), .err(a_err));

  perf_event_counters #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .clr(clr), .reg_wr(reg_wr), .mem_wr(mem_wr), .halt(halt),
    .ic_req(ic_req), .ic_hit(ic_hit), .dc_req(dc_req), .dc_hit(dc_hit),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_valid(b_valid), .rd_data(b_data),
    .done(b_done), .halted(b_halted), .err(b_err));

  // Expected outputs for the cycle after one edge. Counts are unbounded here;
  // a saturating counter that only increments equals min(count, max).
  typedef struct {
    bit    done;
    bit    halted;
    bit    err;
    bit    vld;
    longint val;
  } exp_t;

  exp_t   q[$];
  int     n_pass = 0, n_tot = 0;
  longint m_cnt[6];
  bit     m_halted, m_err, m_done;
  longint m_rd;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic longint sat4(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_halted = 0; m_err = 0; m_done = 0; m_rd = 0;
  endtask

  // Drive one edge's inputs, predict its outcome, then wait out the edge.
  task automatic step(input bit c, input bit h, input bit rw, input bit mw,
                      input bit icr, input bit ich, input bit dcr, input bit dch,
                      input bit re, input bit [2:0] sel);
    exp_t e;
    clr = c; halt = h; reg_wr = rw; mem_wr = mw;
    ic_req = icr; ic_hit = ich; dc_req = dcr; dc_hit = dch;
    rd_en = re; rd_sel = sel;
    if (re) m_rd = (sel < 6) ? m_cnt[sel] : 0;
    if (c) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_err = 0; m_halted = 0; m_done = 0;
    end else if (!m_halted) begin
      m_cnt[0]++;
      if (h || rw || mw) m_cnt[1]++;
      if (icr) m_cnt[2]++;
      if (icr && ich) m_cnt[3]++;
      if (dcr) m_cnt[4]++;
      if (dcr && dch) m_cnt[5]++;
      if ((ich && !icr) || (dch && !dcr)) m_err = 1;
      m_done = h;
      if (h) m_halted = 1;
    end else m_done = 0;
    e.done = m_done; e.halted = m_halted; e.err = m_err; e.vld = re; e.val = m_rd;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0,0,0,0, 0,0,0,0, 0,3'd0);
  endtask

  task automatic rd(input bit [2:0] sel);
    step(0,0,0,0, 0,0,0,0, 1,sel);
  endtask

  // Monitor: every edge that had stimulus gets its expectation checked.
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("done",     a_done,   mon_e.done);
      chk("halted",   a_halted, mon_e.halted);
      chk("err",      a_err,    mon_e.err);
      chk("rd_valid", a_valid,  mon_e.vld);
      chk("rd_data",  a_data,   mon_e.val);
      chk("done4",    b_done,   mon_e.done);
      chk("halted4",  b_halted, mon_e.halted);
      chk("err4",     b_err,    mon_e.err);
      chk("rd_valid4", b_valid, mon_e.vld);
      chk("rd_data4", b_data,   sat4(mon_e.val));
    end
  end

  initial begin
    model_reset();
    #2;
    chk("rst_valid", a_valid, 0); chk("rst_data", a_data, 0);
    chk("rst_done", a_done, 0);   chk("rst_halted", a_halted, 0);
    chk("rst_err", a_err, 0);
    @(negedge clk);
    rst = 1;

    // Halt on the 10th edge, then confirm counters are frozen.
    idle(9);
    step(0,1,0,0, 0,0,0,0, 0,3'd0);
    rd(3'd0); rd(3'd1);
    step(0,1,1,1, 1,1,1,1, 0,3'd0);   // ignored while halted
    idle(4);
    rd(3'd0);

    // I-cache: 8 requests, 6 hits.
    step(1,0,0,0, 0,0,0,0, 0,3'd0);
    for (int i = 0; i < 8; i++) step(0,0,0,0, 1,(i < 6),0,0, 0,3'd0);
    rd(3'd2); rd(3'd3);

    // D-cache hit without request -> sticky err, then clear.
    step(0,0,0,0, 0,0,0,1, 0,3'd0);
    idle(3);
    step(1,0,0,0, 0,0,0,0, 0,3'd0);
    idle(1);

    // Saturation on the 4-bit instance.
    for (int i = 0; i < 20; i++) step(0,0,1,0, 0,0,0,0, 0,3'd0);
    rd(3'd1); rd(3'd0);

    // clr and halt together: clear wins, no done, counting resumes.
    step(1,0,0,0, 0,0,0,0, 0,3'd0);
    idle(7);
    step(1,1,0,0, 0,0,0,0, 1,3'd0);   // read returns pre-clear value
    rd(3'd0); rd(3'd1); rd(3'd0); rd(3'd6); rd(3'd7);

    // Read on the same edge as reg_wr returns the old count.
    for (int i = 0; i < 3; i++) step(0,0,1,0, 0,0,0,0, 0,3'd0);
    step(0,0,1,0, 0,0,0,0, 1,3'd1);
    rd(3'd1);

    // Asynchronous reset between edges.
    step(0,1,0,0, 0,0,0,1, 1,3'd0);
    #2 rst = 0;
    #1;
    chk("arst_valid", a_valid, 0);  chk("arst_data", a_data, 0);
    chk("arst_done", a_done, 0);    chk("arst_halted", a_halted, 0);
    chk("arst_err", a_err, 0);      chk("arst_data4", b_data, 0);
    model_reset();
    q.delete();
    @(negedge clk);
    rst = 1;
    rd(3'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0,39) == 0), ($urandom_range(0,29) == 0),
           $urandom_range(0,1), $urandom_range(0,1),
           $urandom_range(0,1), $urandom_range(0,1),
           $urandom_range(0,1), $urandom_range(0,1),
           $urandom_range(0,1), 3'($urandom_range(0,7)));
    end
    idle(1);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) chk("drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
